// File: rtl/mqueue_pkg.sv
// Shared definitions for the message-queue slots: default geometry, the
// producer FSM encoding and the status record aggregated by the host block.
package mqueue_pkg;

    localparam int c_mqueue_default_entries_log2 = 2;
    localparam int c_mqueue_default_words_log2   = 7;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CLAIMED = 1'b1
    } t_prod_state;

    typedef struct packed {
        logic [c_mqueue_default_entries_log2:0] count;
        logic                                   full;
        logic                                   empty;
        logic                                   claimed;
        logic [c_mqueue_default_words_log2:0]   size;
    } t_mqueue_slot_status;

endpackage

// File: rtl/mqueue_slot_ram.sv
// Simple dual-port message RAM: one write port, one registered read port.
module mqueue_slot_ram #(
    parameter int g_addr_width = 9,
    parameter int g_data_width = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [g_addr_width-1:0] wr_addr,
    input  logic [g_data_width-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [g_addr_width-1:0] rd_addr,
    output logic [g_data_width-1:0] rd_data
);

    logic [g_data_width-1:0] mem [2**g_addr_width];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset so the array still maps to block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mqueue_slot.sv
// One message-queue slot: producer claim/fill/commit ring, consumer
// read/discard of the oldest committed entry.
module mqueue_slot
    import mqueue_pkg::*;
#(
    parameter int g_entries_log2     = c_mqueue_default_entries_log2,
    parameter int g_entry_words_log2 = c_mqueue_default_words_log2,
    parameter int g_data_width       = 32
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_a_i,
    input  logic                          purge_i,
    input  logic                          in_claim_i,
    output logic                          in_claim_ok_o,
    output logic                          in_claim_err_o,
    input  logic                          in_we_i,
    input  logic [g_entry_words_log2-1:0] in_addr_i,
    input  logic [g_data_width-1:0]       in_data_i,
    input  logic                          in_commit_i,
    input  logic [g_entry_words_log2:0]   in_size_i,
    input  logic                          out_rd_i,
    input  logic [g_entry_words_log2-1:0] out_addr_i,
    output logic [g_data_width-1:0]       out_data_o,
    output logic                          out_valid_o,
    output logic [g_entry_words_log2:0]   out_size_o,
    input  logic                          out_discard_i,
    output logic [g_entries_log2:0]       count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          claimed_o
);

    localparam int c_entries = 2**g_entries_log2;
    localparam logic [g_entries_log2:0]     c_full_count = (g_entries_log2+1)'(c_entries);
    localparam logic [g_entry_words_log2:0] c_max_size   = (g_entry_words_log2+1)'(2**g_entry_words_log2);

    t_prod_state                 state_reg, state_next;
    logic [g_entries_log2-1:0]   head_reg, tail_reg;
    logic [g_entries_log2:0]     count_reg;
    logic                        ok_reg, ok_next;
    logic                        err_reg, err_next;
    logic                        valid_reg;
    logic                        commit_fire, wr_fire, discard_fire;
    logic [g_entry_words_log2:0] size_clamped;
    logic [g_entry_words_log2:0] size_vec [c_entries];

    always_comb begin
        state_next  = state_reg;
        ok_next     = 1'b0;
        err_next    = 1'b0;
        commit_fire = 1'b0;
        wr_fire     = 1'b0;
        if (purge_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_claim_i) begin
                        if (count_reg < c_full_count) begin
                            state_next = ST_CLAIMED;
                            ok_next    = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                ST_CLAIMED: begin
                    wr_fire     = in_we_i;
                    commit_fire = in_commit_i;
                    err_next    = in_claim_i;
                    if (in_commit_i) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign discard_fire = out_discard_i && !purge_i && (count_reg != '0);
    assign size_clamped = (in_size_i > c_max_size) ? c_max_size : in_size_i;

    always_ff @(posedge clk_sys_i or posedge rst_a_i) begin
        if (rst_a_i) begin
            state_reg <= ST_IDLE;
            ok_reg    <= 1'b0;
            err_reg   <= 1'b0;
            valid_reg <= 1'b0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ok_reg    <= ok_next;
            err_reg   <= err_next;
            valid_reg <= out_rd_i;
            if (purge_i) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (commit_fire) begin
                    head_reg <= head_reg + 1'b1;
                end
                if (discard_fire) begin
                    tail_reg <= tail_reg + 1'b1;
                end
                case ({commit_fire, discard_fire})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Sizes survive purge; they are only meaningful while count covers them.
    for (genvar gi = 0; gi < c_entries; gi++) begin : g_size
        logic [g_entry_words_log2:0] size_entry_reg;

        always_ff @(posedge clk_sys_i or posedge rst_a_i) begin
            if (rst_a_i) begin
                size_entry_reg <= '0;
            end else if (commit_fire && (head_reg == g_entries_log2'(gi))) begin
                size_entry_reg <= size_clamped;
            end
        end

        assign size_vec[gi] = size_entry_reg;
    end

    mqueue_slot_ram #(
        .g_addr_width (g_entries_log2 + g_entry_words_log2),
        .g_data_width (g_data_width)
    ) u_ram (
        .clk     (clk_sys_i),
        .rst     (rst_a_i),
        .wr_en   (wr_fire),
        .wr_addr ({head_reg, in_addr_i}),
        .wr_data (in_data_i),
        .rd_en   (out_rd_i),
        .rd_addr ({tail_reg, out_addr_i}),
        .rd_data (out_data_o)
    );

    assign in_claim_ok_o  = ok_reg;
    assign in_claim_err_o = err_reg;
    assign out_valid_o    = valid_reg;
    assign out_size_o     = (count_reg == '0) ? '0 : size_vec[tail_reg];
    assign count_o        = count_reg;
    assign full_o         = (count_reg == c_full_count);
    assign empty_o        = (count_reg == '0);
    assign claimed_o      = (state_reg == ST_CLAIMED);

endmodule

// File: tb/tb_mqueue_slot.sv
// Randomized and directed bench for mqueue_slot against a ring-buffer model.
module tb_mqueue_slot;

    localparam int EL = 2;
    localparam int WL = 7;
    localparam int DW = 32;
    localparam int NE = 4;
    localparam int NW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          purge, claim, we, commit, rd, discard;
    logic [WL-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic [WL:0]   wsize;
    logic          ok, err, valid, full, empty, claimed;
    logic [DW-1:0] rdata;
    logic [WL:0]   osize;
    logic [EL:0]   count;

    always #5 clk = ~clk;

    mqueue_slot #(
        .g_entries_log2     (EL),
        .g_entry_words_log2 (WL),
        .g_data_width       (DW)
    ) dut (
        .clk_sys_i      (clk),
        .rst_a_i        (rst),
        .purge_i        (purge),
        .in_claim_i     (claim),
        .in_claim_ok_o  (ok),
        .in_claim_err_o (err),
        .in_we_i        (we),
        .in_addr_i      (waddr),
        .in_data_i      (wdata),
        .in_commit_i    (commit),
        .in_size_i      (wsize),
        .out_rd_i       (rd),
        .out_addr_i     (raddr),
        .out_data_o     (rdata),
        .out_valid_o    (valid),
        .out_size_o     (osize),
        .out_discard_i  (discard),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .claimed_o      (claimed)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: ring of entries, each with a word array and a size.
    int            m_head, m_tail, m_count;
    bit            m_claimed;
    int            m_size [NE];
    logic [DW-1:0] m_mem  [NE][NW];
    bit            m_wr   [NE][NW];
    bit            e_ok, e_err, e_valid, e_dchk;
    logic [DW-1:0] e_data;

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_count = 0; m_claimed = 0;
        for (int i = 0; i < NE; i++) m_size[i] = 0;
        e_ok = 0; e_err = 0; e_valid = 0; e_dchk = 0; e_data = '0;
    endtask

    task automatic idle_inputs();
        purge = 0; claim = 0; we = 0; commit = 0; rd = 0; discard = 0;
        waddr = '0; raddr = '0; wdata = '0; wsize = '0;
    endtask

    task automatic compare_all();
        check("claim_ok", ok, e_ok);
        check("claim_err", err, e_err);
        check("valid", valid, e_valid);
        if (e_dchk) check("rd_data", rdata, e_data);
        check("count", count, m_count);
        check("full", full, m_count == NE);
        check("empty", empty, m_count == 0);
        check("claimed", claimed, m_claimed);
        check("size", osize, (m_count > 0) ? m_size[m_tail] : 0);
    endtask

    task automatic step();
        int inc;
        int dec;
        inc = 0; dec = 0;
        e_ok = 0; e_err = 0;
        e_valid = rd;
        e_dchk  = rd && (m_count > 0) && m_wr[m_tail][raddr];
        e_data  = m_mem[m_tail][raddr];
        if (purge) begin
            m_head = 0; m_tail = 0; m_count = 0; m_claimed = 0;
        end else begin
            if (claim) begin
                if (!m_claimed && m_count < NE) e_ok = 1;
                else e_err = 1;
            end
            if (m_claimed && we) begin
                m_mem[m_head][waddr] = wdata;
                m_wr[m_head][waddr]  = 1;
            end
            if (m_claimed && commit) begin
                m_size[m_head] = (int'(wsize) > NW) ? NW : int'(wsize);
                m_head = (m_head + 1) % NE;
                inc = 1;
                m_claimed = 0;
            end else if (e_ok) begin
                m_claimed = 1;
            end
            if (discard && m_count > 0) begin
                m_tail = (m_tail + 1) % NE;
                dec = 1;
            end
            m_count = m_count + inc - dec;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_claim();
        claim = 1; step(); claim = 0;
        $display("claim   ok=%0b err=%0b count=%0d", ok, err, count);
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        we = 1; waddr = WL'(a); wdata = d; step(); we = 0;
        $display("write   addr=%0d data=0x%0h", a, d);
    endtask

    task automatic do_commit(input int s);
        commit = 1; wsize = (WL+1)'(s); step(); commit = 0;
        $display("commit  size=%0d count=%0d out_size=%0d", s, count, osize);
    endtask

    task automatic do_discard();
        discard = 1; step(); discard = 0;
        $display("discard count=%0d", count);
    endtask

    task automatic do_read(input int a);
        rd = 1; raddr = WL'(a); step(); rd = 0;
        $display("read    addr=%0d data=0x%0h", a, rdata);
    endtask

    initial begin
        idle_inputs();
        for (int e = 0; e < NE; e++)
            for (int w = 0; w < NW; w++) begin
                m_mem[e][w] = '0;
                m_wr[e][w]  = 0;
            end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("reset_data", rdata, 0);
        rst = 0;

        // Single entry, back-to-back readback.
        do_claim();
        check("t1_ok", ok, 1);
        for (int i = 0; i < 4; i++) do_write(i, DW'(32'h11 * (i + 1)));
        do_commit(4);
        check("t1_count", count, 1);
        check("t1_size", osize, 4);
        rd = 1;
        for (int i = 0; i < 4; i++) begin
            raddr = WL'(i);
            step();
            check("t1_rd", rdata, 32'h11 * (i + 1));
            $display("read    addr=%0d data=0x%0h", i, rdata);
        end
        rd = 0;
        step();

        // Fill to full, refused claims, then reopen.
        for (int i = 1; i < NE; i++) begin
            do_claim();
            do_write(0, DW'(32'hF0 + i));
            do_commit(i + 1);
        end
        check("t2_full", full, 1);
        do_claim();
        check("t2_err_full", err, 1);
        check("t2_count", count, NE);
        claim = 1; discard = 1; step(); claim = 0; discard = 0;
        check("t2_err_disc", err, 1);
        check("t2_count3", count, NE - 1);
        do_claim();
        check("t2_ok", ok, 1);
        do_commit(4);
        for (int i = 0; i < NE; i++) do_discard();

        // Wrap-around rounds.
        for (int r = 0; r < 10; r++) begin
            do_claim();
            do_write(0, DW'(r));
            do_commit(1);
            do_read(0);
            check("t3_rd", rdata, r);
            do_discard();
        end
        check("t3_count", count, 0);
        check("t3_empty", empty, 1);

        // Simultaneous commit and discard at count 2.
        do_claim(); do_write(0, 32'hA0); do_commit(5);
        do_claim(); do_write(0, 32'hB0); do_commit(6);
        do_claim(); do_write(0, 32'hC0);
        commit = 1; wsize = 7; discard = 1; step(); commit = 0; discard = 0;
        check("t4_count", count, 2);
        check("t4_size", osize, 6);
        do_read(0);
        check("t4_rd", rdata, 32'hB0);
        do_discard(); do_discard();

        // Double claim and oversize commit.
        do_claim();
        do_claim();
        check("t5_err", err, 1);
        check("t5_claimed", claimed, 1);
        do_commit(200);
        check("t5_clamp", osize, NW);

        // Purge while claimed at count 3.
        do_claim(); do_commit(2);
        do_claim(); do_commit(3);
        do_claim();
        check("t6_count3", count, 3);
        purge = 1; step(); purge = 0;
        check("t6_count", count, 0);
        check("t6_empty", empty, 1);
        check("t6_claimed", claimed, 0);

        // Asynchronous reset in the middle of streaming reads.
        do_claim(); do_write(0, 32'h5A); do_write(1, 32'h5B); do_commit(2);
        rd = 1; raddr = 0; step(); raddr = 1; step();
        rst = 1;
        #1;
        check("t7_valid", valid, 0);
        check("t7_count", count, 0);
        model_reset();
        rd = 0;
        @(posedge clk);
        #1;
        rst = 0;
        step();
        $display("reset   valid=%0b ok=%0b err=%0b", valid, ok, err);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            purge   = ($urandom_range(0, 199) == 0);
            claim   = ($urandom_range(0, 99) < 15);
            we      = ($urandom_range(0, 1) == 1);
            waddr   = WL'($urandom_range(0, NW - 1));
            wdata   = DW'($urandom);
            commit  = ($urandom_range(0, 99) < 10);
            wsize   = (WL+1)'($urandom_range(0, 200));
            rd      = ($urandom_range(0, 99) < 40);
            raddr   = WL'($urandom_range(0, NW - 1));
            discard = ($urandom_range(0, 99) < 12);
            step();
        end
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mqueue_slot.md
# mqueue_slot

One message-queue slot for the node core: a ring of fixed-size message entries written by a node CPU (producer) and drained by the host over the VME/Wishbone bridge (consumer). The producer claims an entry, fills it, then commits it with a word count. The host polls the status, reads words of the oldest entry and discards it. Eight instances sit behind the host message queue block, giving the hardware end of the protocol the host driver polls.

## Interface
- g_entries_log2, 2: the ring holds 2^g_entries_log2 entries.
- g_entry_words_log2, 7: each entry holds 2^g_entry_words_log2 words.
- g_data_width, 32: word width.

Ports:
- clk_sys_i  in  1  system clock; the only clock.
- rst_a_i  in  1  reset, asynchronous, active-high.
- purge_i  in  1  synchronous pulse that flushes the slot.
- in_claim_i  in  1  producer claims the head entry (pulse).
- in_claim_ok_o  out  1  pulse: claim accepted.
- in_claim_err_o  out  1  pulse: claim refused (full or already claimed).
- in_we_i  in  1  write strobe into the claimed entry.
- in_addr_i  in  g_entry_words_log2  word index within the entry.
- in_data_i  in  g_data_width  write data.
- in_commit_i  in  1  publishes the claimed entry (pulse).
- in_size_i  in  g_entry_words_log2+1  valid word count, sampled at commit.
- out_rd_i  in  1  consumer read strobe.
- out_addr_i  in  g_entry_words_log2  word index within the tail entry.
- out_data_o  out  g_data_width  read data.
- out_valid_o  out  1  read data valid.
- out_size_o  out  g_entry_words_log2+1  committed size of the tail entry.
- out_discard_i  in  1  releases the tail entry (pulse).
- count_o  out  g_entries_log2+1  number of committed entries.
- full_o, empty_o  out  1  count_o == 2^g_entries_log2, count_o == 0.
- claimed_o  out  1  the producer holds a claim.

## Operation
- State: head and tail pointers (g_entries_log2 bits, wrapping modulo the entry count), count, a per-entry size register array, and a producer FSM.
- Producer FSM states IDLE and CLAIMED.
- IDLE, in_claim_i with count < 2^g_entries_log2: go to CLAIMED and pulse in_claim_ok_o. Otherwise pulse in_claim_err_o and stay in IDLE.
- CLAIMED, in_we_i: writes RAM[{head, in_addr_i}]. in_we_i is ignored in IDLE.
- CLAIMED, in_claim_i: pulses in_claim_err_o; state unchanged.
- CLAIMED, in_commit_i: size[head] <= min(in_size_i, 2^g_entry_words_log2); head++; count++; go to IDLE. in_commit_i is ignored in IDLE.
- in_we_i and in_commit_i in the same cycle: the write lands before the commit takes effect.
- out_rd_i: reads RAM[{tail, out_addr_i}]. When empty the data is don't-care, but out_valid_o still pulses.
- out_size_o = size[tail]; it is 0 when empty.
- out_discard_i with count > 0: tail++ and count--. Ignored when empty.
- Commit and discard in the same cycle: count unchanged, both pointers advance.
- A claim while full is refused even if a discard arrives in the same cycle (full is evaluated on the pre-edge count).
- Discards never disturb a claimed entry: a claim is only granted when count < 2^g_entries_log2, so head never equals an occupied tail slot.
- purge_i has priority over every other input. It clears head, tail and count, returns the FSM to IDLE, and suppresses ok/err pulses that cycle. RAM contents are not cleared.

## Timing
- Reset values: all outputs 0 except empty_o = 1. Pointers and count are 0, size array 0, FSM IDLE.
- in_claim_ok_o and in_claim_err_o: registered, one cycle after in_claim_i, one cycle wide.
- Read latency: out_data_o and out_valid_o one cycle after out_rd_i. out_rd_i may be held high for back-to-back reads at one word per cycle.
- count_o, full_o, empty_o, claimed_o and out_size_o update on the edge that samples commit, discard or purge.
- A committed entry is readable on the cycle after the commit edge.
- rst_a_i asserted mid-claim or mid-read: immediate return to reset values; no pulse is emitted after reset release.

## Structure
- Package mqueue_pkg holds:
  - c_mqueue_default_entries_log2 and c_mqueue_default_words_log2;
  - the t_mqueue_slot_status record (count, full, empty, claimed, size), used by the host block to aggregate the eight slots.
- Sub-module mqueue_slot_ram: a simple dual-port RAM, 2^(g_entries_log2+g_entry_words_log2) by g_data_width, with one write port, one registered read port and a single clock.
- FSM, pointers and size array live in mqueue_slot itself.

## Test plan
- After reset: claim, write words 0..3 = 0x11,0x22,0x33,0x44, commit with size 4 -> count_o=1, out_size_o=4; reading addresses 0..3 back-to-back returns 0x11..0x44 with 1-cycle latency.
- Fill 4 entries (default depth) -> full_o=1. A 5th claim gives in_claim_err_o with count unchanged. Discard once, then claim -> in_claim_ok_o.
- Wrap-around: 10 commit/read/discard rounds with payload = round number -> every read matches, count_o returns to 0, empty_o=1.
- Commit and discard in the same cycle with count=2 -> count stays 2, tail entry advances to the next message.
- Claim while already CLAIMED -> in_claim_err_o, claimed_o stays 1. Commit with in_size_i=200 (above 128) -> out_size_o=128.
- purge_i while CLAIMED with count=3 -> count_o=0, empty_o=1, claimed_o=0. rst_a_i mid back-to-back read -> out_valid_o drops to 0 immediately.
